// File: rtl/padovan_pkg.sv
// Shared constants and checker state encoding for the Padovan stream sink.
package padovan_pkg;

  localparam int unsigned W_DEFAULT     = 16;
  localparam int unsigned DEPTH_DEFAULT = 8;
  localparam int unsigned DROP_CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WARM  = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/padovan_stream_sink_if.sv
// Upstream term stream, downstream FIFO head and status flags of the sink.
interface padovan_stream_sink_if #(
  parameter int unsigned W = padovan_pkg::W_DEFAULT
);
  logic [W-1:0]                       in_f_n;
  logic [W-1:0]                       in_n;
  logic                               in_valid;
  logic [2*W-1:0]                     out_data;
  logic                               out_valid;
  logic                               out_ready;
  logic                               err_seq;
  logic                               err_idx;
  logic                               overflow;
  logic [padovan_pkg::DROP_CNT_W-1:0] drop_cnt;
  logic                               halted;

  modport master (
    output in_f_n, in_n, in_valid, out_ready,
    input  out_data, out_valid, err_seq, err_idx, overflow, drop_cnt, halted
  );

  modport slave (
    input  in_f_n, in_n, in_valid, out_ready,
    output out_data, out_valid, err_seq, err_idx, overflow, drop_cnt, halted
  );
endinterface

// File: rtl/padovan_sync_fifo.sv
// Synchronous FIFO with a registered head and an occupancy counter 0..DEPTH.
module padovan_sync_fifo #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_c,
  input  logic [DW-1:0] wdata,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          drop_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;

  logic pop_c;
  logic full_c;
  logic wr_en_c;

  assign pop_c   = out_valid_q && out_ready;
  assign full_c  = (count_q == CW'(DEPTH));
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en_c = push_c && (!full_c || pop_c);
  assign drop_c  = push_c && !wr_en_c;

  always_comb begin
    mem_d       = mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (wr_en_c) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_en_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // The next head is either already stored or is the word being written now.
    out_valid_d = (count_d != '0);
    if (count_d != '0) begin
      if (wr_en_c && (rd_ptr_d == wr_ptr_q)) begin
        out_data_d = wdata;
      end else begin
        out_data_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q       <= '{default: '0};
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: rtl/padovan_stream_sink.sv
// Buffers an upstream Padovan stream in a FIFO and checks its recurrence and indices.
module padovan_stream_sink
  import padovan_pkg::*;
#(
  parameter int unsigned W     = W_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input logic                 clk,
  input logic                 rst,
  padovan_stream_sink_if.slave bus
);

  state_e                state_q, state_d;
  logic                  warm_cnt_q, warm_cnt_d;
  logic [W-1:0]          t1_q, t1_d;
  logic [W-1:0]          t2_q, t2_d;
  logic [W-1:0]          t3_q, t3_d;
  logic [W-1:0]          prev_n_q, prev_n_d;
  logic                  err_seq_q, err_seq_d;
  logic                  err_idx_q, err_idx_d;
  logic                  overflow_q, overflow_d;
  logic                  halted_q, halted_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic       push_req_c;
  logic       drop_c;
  logic [W:0] sum_c;
  logic       idx_ok_c;

  assign push_req_c = bus.in_valid && (state_q != HALT);
  assign sum_c      = {1'b0, t2_q} + {1'b0, t3_q};
  assign idx_ok_c   = (bus.in_n == prev_n_q + W'(1));

  padovan_sync_fifo #(
    .DW    (2 * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_c    (push_req_c),
    .wdata     ({bus.in_n, bus.in_f_n}),
    .out_ready (bus.out_ready),
    .out_data  (bus.out_data),
    .out_valid (bus.out_valid),
    .drop_c    (drop_c)
  );

  // Checker: dropped terms are still checked, only the FIFO write is lost.
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    t1_d       = t1_q;
    t2_d       = t2_q;
    t3_d       = t3_q;
    prev_n_d   = prev_n_q;
    err_seq_d  = err_seq_q;
    err_idx_d  = err_idx_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          t1_d       = bus.in_f_n;
          prev_n_d   = bus.in_n;
          warm_cnt_d = 1'b0;
          state_d    = WARM;
        end
      end
      WARM, CHECK: begin
        if (bus.in_valid) begin
          t3_d     = t2_q;
          t2_d     = t1_q;
          t1_d     = bus.in_f_n;
          prev_n_d = bus.in_n;
          if (!idx_ok_c) begin
            err_idx_d = 1'b1;
          end
          if (state_q == CHECK) begin
            if ({1'b0, bus.in_f_n} != sum_c) begin
              err_seq_d = 1'b1;
            end
          end else begin
            warm_cnt_d = 1'b1;
            if (warm_cnt_q) begin
              state_d = CHECK;
            end
          end
        end else begin
          state_d = HALT;
        end
      end
      default: state_d = state_q;
    endcase

    if (drop_c) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end
    end

    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      warm_cnt_q <= 1'b0;
      t1_q       <= '0;
      t2_q       <= '0;
      t3_q       <= '0;
      prev_n_q   <= '0;
      err_seq_q  <= 1'b0;
      err_idx_q  <= 1'b0;
      overflow_q <= 1'b0;
      halted_q   <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      t1_q       <= t1_d;
      t2_q       <= t2_d;
      t3_q       <= t3_d;
      prev_n_q   <= prev_n_d;
      err_seq_q  <= err_seq_d;
      err_idx_q  <= err_idx_d;
      overflow_q <= overflow_d;
      halted_q   <= halted_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.err_seq  = err_seq_q;
  assign bus.err_idx  = err_idx_q;
  assign bus.overflow = overflow_q;
  assign bus.drop_cnt = drop_cnt_q;
  assign bus.halted   = halted_q;

endmodule
